// File: rtl/traffic_intersection_ctrl_if.sv
// rtl/traffic_intersection_ctrl_if.sv - control/lamp bundle between tick source, controller and lamp drivers
interface traffic_intersection_ctrl_if #(
    parameter int PHASES = 2
);
    localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

    logic                  en_i;
    logic                  mode_night_i;
    logic [PHASES-1:0]     ped_req_i;
    logic [3*PHASES-1:0]   lamp_o;
    logic [PHASES-1:0]     walk_o;
    logic [PH_W-1:0]       phase_o;

    modport master (
        output en_i, mode_night_i, ped_req_i,
        input  lamp_o, walk_o, phase_o
    );

    modport slave (
        input  en_i, mode_night_i, ped_req_i,
        output lamp_o, walk_o, phase_o
    );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - multi-phase intersection controller with walk requests and night flash
module traffic_intersection_ctrl #(
    parameter int PHASES     = 2,
    parameter int GREEN_ON   = 40,
    parameter int GREEN_PED  = 60,
    parameter int BLINKING   = 3,
    parameter int YELLOW_ON  = 5,
    parameter int ALL_RED    = 2,
    parameter int NIGHT_HALF = 8,
    parameter int TIMER_W    = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    traffic_intersection_ctrl_if.slave   bus
);
    localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int MAX_A = (GREEN_PED > 2*BLINKING) ? GREEN_PED : 2*BLINKING;
    localparam int MAX_N = (MAX_A > 2*NIGHT_HALF) ? MAX_A : 2*NIGHT_HALF;

    // Every state length minus one must be representable in the shared timer.
    if ((MAX_N - 1) >= (1 << TIMER_W)) begin : g_timer_w_check
        $error("TIMER_W too narrow for the configured durations");
    end

    localparam logic [TIMER_W-1:0] G_LAST  = TIMER_W'(GREEN_ON - 1);
    localparam logic [TIMER_W-1:0] GP_LAST = TIMER_W'(GREEN_PED - 1);
    localparam logic [TIMER_W-1:0] B_LAST  = TIMER_W'(2*BLINKING - 1);
    localparam logic [TIMER_W-1:0] Y_LAST  = TIMER_W'(YELLOW_ON - 1);
    localparam logic [TIMER_W-1:0] R_LAST  = TIMER_W'(ALL_RED - 1);
    localparam logic [TIMER_W-1:0] N_LAST  = TIMER_W'(2*NIGHT_HALF - 1);
    localparam logic [TIMER_W-1:0] N_HALF  = TIMER_W'(NIGHT_HALF);
    localparam logic [PH_W-1:0]    LAST_PH = PH_W'(PHASES - 1);

    typedef enum logic [2:0] {
        S_GREEN  = 3'd0,
        S_BLINK  = 3'd1,
        S_YELLOW = 3'd2,
        S_ALLRED = 3'd3,
        S_NIGHT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PHASES-1:0]   ped_pend_q, ped_pend_d;
    logic [PHASES-1:0]   walk_q, walk_d;
    logic                dark_q;

    logic [TIMER_W-1:0]  last_cnt;
    logic                at_last;
    logic [PH_W-1:0]     next_phase;
    logic [PHASES-1:0]   ped_clr;
    logic [3*PHASES-1:0] lamp;

    // State, timer, phase and request registers; dark tracks the enable one cycle late.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_ALLRED;
            phase_q    <= LAST_PH;
            timer_q    <= '0;
            ped_pend_q <= '0;
            walk_q     <= '0;
            dark_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
            dark_q     <= ~bus.en_i;
        end
    end

    // Next-state, timer and walk decisions; everything freezes while en_i is low.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        timer_d    = timer_q;
        walk_d     = walk_q;
        ped_clr    = '0;
        next_phase = (phase_q >= LAST_PH) ? '0 : phase_q + 1'b1;

        case (state_q)
            S_GREEN:  last_cnt = (|walk_q) ? GP_LAST : G_LAST;
            S_BLINK:  last_cnt = B_LAST;
            S_YELLOW: last_cnt = Y_LAST;
            S_ALLRED: last_cnt = R_LAST;
            S_NIGHT:  last_cnt = N_LAST;
            default:  last_cnt = '0;
        endcase
        at_last = (timer_q == last_cnt);

        if (bus.en_i) begin
            timer_d = at_last ? '0 : timer_q + 1'b1;
            case (state_q)
                S_GREEN: if (at_last) begin
                    state_d = S_BLINK;
                    walk_d  = '0;
                end
                S_BLINK:  if (at_last) state_d = S_YELLOW;
                S_YELLOW: if (at_last) state_d = S_ALLRED;
                S_ALLRED: if (at_last) begin
                    if (bus.mode_night_i) begin
                        state_d = S_NIGHT;
                    end else begin
                        state_d = S_GREEN;
                        phase_d = next_phase;
                        if (ped_pend_q[next_phase]) begin
                            walk_d[next_phase]  = 1'b1;
                            ped_clr[next_phase] = 1'b1;
                        end
                    end
                end
                S_NIGHT: if (at_last && !bus.mode_night_i) begin
                    state_d = S_ALLRED;
                    phase_d = LAST_PH;
                end
                default: begin
                    state_d = S_ALLRED;
                    phase_d = LAST_PH;
                    timer_d = '0;
                    walk_d  = '0;
                end
            endcase
        end

        // A request arriving on the grant cycle wins over the clear.
        ped_pend_d = (ped_pend_q & ~ped_clr) | bus.ped_req_i;
    end

    // Lamp decode from registered state; all lamps dark while disabled.
    always_comb begin
        lamp = '0;
        for (int k = 0; k < PHASES; k++) begin
            if (state_q == S_NIGHT) begin
                lamp[3*k+1] = (timer_q < N_HALF);
            end else if (PH_W'(k) != phase_q) begin
                lamp[3*k+2] = 1'b1;
            end else begin
                case (state_q)
                    S_GREEN:  lamp[3*k]   = 1'b1;
                    S_BLINK:  lamp[3*k]   = timer_q[0];
                    S_YELLOW: lamp[3*k+1] = 1'b1;
                    default:  lamp[3*k+2] = 1'b1;
                endcase
            end
        end
        if (dark_q) lamp = '0;
    end

    assign bus.lamp_o  = lamp;
    assign bus.walk_o  = walk_q & {PHASES{~dark_q}};
    assign bus.phase_o = phase_q;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - directed self-checking bench for traffic_intersection_ctrl
module tb_traffic_intersection_ctrl;
    localparam logic [5:0] L_DARK = 6'b000_000;
    localparam logic [5:0] L_RED  = 6'b100_100;
    localparam logic [5:0] L_G0   = 6'b100_001;
    localparam logic [5:0] L_B0   = 6'b100_000;
    localparam logic [5:0] L_Y0   = 6'b100_010;
    localparam logic [5:0] L_G1   = 6'b001_100;
    localparam logic [5:0] L_B1   = 6'b000_100;
    localparam logic [5:0] L_NY   = 6'b010_010;

    logic clk = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;
    logic mon_b = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   t = 0;

    always #5 clk = ~clk;

    traffic_intersection_ctrl_if #(.PHASES(2)) if_a ();
    traffic_intersection_ctrl_if #(.PHASES(4)) if_b ();

    traffic_intersection_ctrl dut_a (
        .clk  (clk),
        .rstn (rstn_a),
        .bus  (if_a)
    );

    traffic_intersection_ctrl #(
        .PHASES(4), .GREEN_ON(3), .GREEN_PED(4), .BLINKING(1),
        .YELLOW_ON(2), .ALL_RED(1), .NIGHT_HALF(2), .TIMER_W(4)
    ) dut_b (
        .clk  (clk),
        .rstn (rstn_b),
        .bus  (if_b)
    );

    // Safety monitor on the 4-approach instance: never two non-RED approaches while lit.
    always @(negedge clk) begin
        if (mon_b && (if_b.lamp_o !== 12'd0)) begin
            int n;
            n = 0;
            for (int k = 0; k < 4; k++) if (if_b.lamp_o[3*k +: 3] !== 3'b100) n++;
            tests++;
            if (n > 1) begin fails++; $display("FAIL safety_b: lamp=%b has %0d non-red approaches, required <=1", if_b.lamp_o, n); end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        t += n;
    endtask

    task automatic adv_to(input int target);
        adv(target - t);
    endtask

    task automatic sync_reset;
        rstn_a = 1'b0;
        if_a.en_i = 1'b1;
        if_a.mode_night_i = 1'b0;
        if_a.ped_req_i = 2'b00;
        adv(2);
        rstn_a = 1'b1;
        adv(2);
        t = 0;
    endtask

    function automatic logic [11:0] exp_b(input int p);
        logic [11:0] v;
        for (int k = 0; k < 4; k++) v[3*k +: 3] = (k == p) ? 3'b001 : 3'b100;
        return v;
    endfunction

    task automatic test_reset;
        if_a.en_i = 1'b1;
        if_a.mode_night_i = 1'b0;
        if_a.ped_req_i = 2'b00;
        adv(2);
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL reset_lamp: got %b required %b", if_a.lamp_o, L_DARK); end
        tests++; if (if_a.phase_o !== 1'b1) begin fails++; $display("FAIL reset_phase: got %0d required 1", if_a.phase_o); end
        tests++; if (if_a.walk_o !== 2'b00) begin fails++; $display("FAIL reset_walk: got %b required 00", if_a.walk_o); end
        rstn_a = 1'b1;
        #1;
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL release_dark: got %b required %b", if_a.lamp_o, L_DARK); end
        adv(1);
        tests++; if (if_a.lamp_o !== L_RED) begin fails++; $display("FAIL first_allred: got %b required %b", if_a.lamp_o, L_RED); end
        adv(1);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL first_green: got %b required %b", if_a.lamp_o, L_G0); end
        tests++; if (if_a.phase_o !== 1'b0) begin fails++; $display("FAIL first_phase: got %0d required 0", if_a.phase_o); end
        t = 0;
    endtask

    task automatic test_sequence;
        adv_to(39);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL green_end: got %b required %b", if_a.lamp_o, L_G0); end
        for (int i = 40; i < 46; i++) begin
            adv_to(i);
            tests++;
            if (if_a.lamp_o !== (((i - 40) % 2 == 1) ? L_G0 : L_B0)) begin fails++; $display("FAIL blink_%0d: got %b", i - 40, if_a.lamp_o); end
        end
        adv_to(46);
        tests++; if (if_a.lamp_o !== L_Y0) begin fails++; $display("FAIL yellow_start: got %b required %b", if_a.lamp_o, L_Y0); end
        adv_to(50);
        tests++; if (if_a.lamp_o !== L_Y0) begin fails++; $display("FAIL yellow_end: got %b required %b", if_a.lamp_o, L_Y0); end
        adv_to(51);
        tests++; if (if_a.lamp_o !== L_RED) begin fails++; $display("FAIL allred_start: got %b required %b", if_a.lamp_o, L_RED); end
        adv_to(52);
        tests++; if (if_a.lamp_o !== L_RED) begin fails++; $display("FAIL allred_end: got %b required %b", if_a.lamp_o, L_RED); end
        adv_to(53);
        tests++; if (if_a.lamp_o !== L_G1) begin fails++; $display("FAIL ph1_green: got %b required %b", if_a.lamp_o, L_G1); end
        tests++; if (if_a.phase_o !== 1'b1) begin fails++; $display("FAIL ph1_phase: got %0d required 1", if_a.phase_o); end
    endtask

    task automatic test_enable_freeze;
        sync_reset();
        adv_to(20);
        if_a.en_i = 1'b0;
        adv(1);
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL freeze_dark: got %b required %b", if_a.lamp_o, L_DARK); end
        adv(9);
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL freeze_dark_end: got %b required %b", if_a.lamp_o, L_DARK); end
        tests++; if (if_a.phase_o !== 1'b0) begin fails++; $display("FAIL freeze_phase: got %0d required 0", if_a.phase_o); end
        if_a.en_i = 1'b1;
        adv(1);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL relight: got %b required %b", if_a.lamp_o, L_G0); end
        adv(18);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL freeze_green_end: got %b required %b", if_a.lamp_o, L_G0); end
        adv(1);
        tests++; if (if_a.lamp_o !== L_B0) begin fails++; $display("FAIL freeze_blink: got %b required %b", if_a.lamp_o, L_B0); end
    endtask

    task automatic test_ped;
        sync_reset();
        if_a.ped_req_i = 2'b10;
        adv(1);
        if_a.ped_req_i = 2'b00;
        tests++; if (if_a.walk_o !== 2'b00) begin fails++; $display("FAIL ped_no_walk_ph0: got %b required 00", if_a.walk_o); end
        adv_to(52);
        if_a.ped_req_i = 2'b10;
        adv(1);
        if_a.ped_req_i = 2'b00;
        tests++; if (if_a.lamp_o !== L_G1) begin fails++; $display("FAIL ped_green: got %b required %b", if_a.lamp_o, L_G1); end
        tests++; if (if_a.walk_o !== 2'b10) begin fails++; $display("FAIL ped_walk_start: got %b required 10", if_a.walk_o); end
        adv_to(112);
        tests++; if (if_a.lamp_o !== L_G1) begin fails++; $display("FAIL ped_green_end: got %b required %b", if_a.lamp_o, L_G1); end
        tests++; if (if_a.walk_o !== 2'b10) begin fails++; $display("FAIL ped_walk_end: got %b required 10", if_a.walk_o); end
        adv_to(113);
        tests++; if (if_a.lamp_o !== L_B1) begin fails++; $display("FAIL ped_blink: got %b required %b", if_a.lamp_o, L_B1); end
        tests++; if (if_a.walk_o !== 2'b00) begin fails++; $display("FAIL ped_walk_off: got %b required 00", if_a.walk_o); end
        adv_to(126);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL ped_rot_g0: got %b required %b", if_a.lamp_o, L_G0); end
        adv_to(179);
        tests++; if (if_a.walk_o !== 2'b10) begin fails++; $display("FAIL ped_entry_req_kept: got %b required 10", if_a.walk_o); end
        adv_to(305);
        tests++; if (if_a.lamp_o !== L_G1) begin fails++; $display("FAIL ped_rot3_g1: got %b required %b", if_a.lamp_o, L_G1); end
        tests++; if (if_a.walk_o !== 2'b00) begin fails++; $display("FAIL ped_cleared: got %b required 00", if_a.walk_o); end
        adv_to(345);
        tests++; if (if_a.lamp_o !== L_B1) begin fails++; $display("FAIL ped_plain_len: got %b required %b", if_a.lamp_o, L_B1); end
    endtask

    task automatic test_night;
        sync_reset();
        adv_to(10);
        if_a.mode_night_i = 1'b1;
        adv_to(40);
        tests++; if (if_a.lamp_o !== L_B0) begin fails++; $display("FAIL night_green_done: got %b required %b", if_a.lamp_o, L_B0); end
        adv_to(52);
        tests++; if (if_a.lamp_o !== L_RED) begin fails++; $display("FAIL night_allred: got %b required %b", if_a.lamp_o, L_RED); end
        adv_to(53);
        tests++; if (if_a.lamp_o !== L_NY) begin fails++; $display("FAIL night_on: got %b required %b", if_a.lamp_o, L_NY); end
        adv_to(60);
        tests++; if (if_a.lamp_o !== L_NY) begin fails++; $display("FAIL night_on_end: got %b required %b", if_a.lamp_o, L_NY); end
        adv_to(61);
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL night_off: got %b required %b", if_a.lamp_o, L_DARK); end
        adv_to(69);
        tests++; if (if_a.lamp_o !== L_NY) begin fails++; $display("FAIL night_wrap: got %b required %b", if_a.lamp_o, L_NY); end
        adv_to(73);
        if_a.mode_night_i = 1'b0;
        adv_to(84);
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL night_last: got %b required %b", if_a.lamp_o, L_DARK); end
        adv_to(85);
        tests++; if (if_a.lamp_o !== L_RED) begin fails++; $display("FAIL night_exit_red: got %b required %b", if_a.lamp_o, L_RED); end
        tests++; if (if_a.phase_o !== 1'b1) begin fails++; $display("FAIL night_exit_phase: got %0d required 1", if_a.phase_o); end
        adv_to(87);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL night_exit_g0: got %b required %b", if_a.lamp_o, L_G0); end
    endtask

    task automatic test_reset_mid_yellow;
        sync_reset();
        adv_to(48);
        tests++; if (if_a.lamp_o !== L_Y0) begin fails++; $display("FAIL midy_yellow: got %b required %b", if_a.lamp_o, L_Y0); end
        rstn_a = 1'b0;
        #1;
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL midy_async_dark: got %b required %b", if_a.lamp_o, L_DARK); end
        tests++; if (if_a.phase_o !== 1'b1) begin fails++; $display("FAIL midy_async_phase: got %0d required 1", if_a.phase_o); end
        adv(3);
        rstn_a = 1'b1;
        #1;
        tests++; if (if_a.lamp_o !== L_DARK) begin fails++; $display("FAIL midy_release_dark: got %b required %b", if_a.lamp_o, L_DARK); end
        adv(1);
        tests++; if (if_a.lamp_o !== L_RED) begin fails++; $display("FAIL midy_allred: got %b required %b", if_a.lamp_o, L_RED); end
        adv(1);
        tests++; if (if_a.lamp_o !== L_G0) begin fails++; $display("FAIL midy_g0: got %b required %b", if_a.lamp_o, L_G0); end
    endtask

    task automatic test_four_phase;
        mon_b = 1'b1;
        rstn_b = 1'b1;
        adv(1);
        for (int p = 0; p < 5; p++) begin
            tests++; if (if_b.phase_o !== 2'(p % 4)) begin fails++; $display("FAIL four_phase_%0d: got %0d required %0d", p, if_b.phase_o, p % 4); end
            tests++; if (if_b.lamp_o !== exp_b(p % 4)) begin fails++; $display("FAIL four_lamp_%0d: got %b required %b", p, if_b.lamp_o, exp_b(p % 4)); end
            adv(8);
        end
    endtask

    initial begin
        if_b.en_i = 1'b1;
        if_b.mode_night_i = 1'b0;
        if_b.ped_req_i = 4'b0000;
        test_reset();
        test_sequence();
        test_enable_freeze();
        test_ped();
        test_night();
        test_reset_mid_yellow();
        test_four_phase();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
